// File: rtl/matrix_ctrl_pkg.sv
// Shared definitions for the matrix window controller.
// Contents:
//   state_t      - controller FSM states
//   WIN_LATENCY  - cycles from a pixel entering to its window being assembled
//   FIFO_NUM     - number of line FIFOs driven by the controller
package matrix_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      ACTIVE,
      GAP1,
      TAIL1,
      GAP2,
      TAIL2
   } state_t;

   localparam int WIN_LATENCY = 3;
   localparam int FIFO_NUM    = 4;

endpackage

// File: rtl/sig_delay_line.sv
// Fixed-depth shift register used to align control signals with the
// assembled pixel window.
// Ports:
//   clk    - clock, all logic on posedge
//   rst_n  - asynchronous active-low reset, clears every stage
//   din    - WIDTH-bit input sampled every cycle
//   dout   - din delayed by exactly DEPTH cycles
module sig_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] pipe [DEPTH];

   // Plain shift chain; stage DEPTH-1 is the aligned output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe[i] <= '0;
         end
      end else begin
         pipe[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/matrix_window_ctrl.sv
// Line-FIFO and window-timing controller for a 5-row sliding window.
// Raw pixels go to FIFO0; each FIFO feeds the next. After the last input
// line, two synthesized tail rows flush the FIFOs so the bottom border
// windows are produced, each preceded by an idle gap of DELAY_NUM cycles.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   per_img_vsync/href         - input frame / line valid
//   fifo_wr_en/fifo_rd_en      - per-FIFO write / read enables
//   matrix_img_vsync/href      - window-aligned frame / line valid
//   matrix_*_edge_flag         - window touches top/bottom/left/right border
//   busy                       - controller not idle
//   frame_err                  - sticky protocol error
// Optional feature: define FRAME_ERR_CHK_EN to build the protocol checker;
// without it frame_err is tied low.
module matrix_window_ctrl
   import matrix_ctrl_pkg::*;
#(
   parameter int IMG_H_DISP = 640,
   parameter int IMG_V_DISP = 480,
   parameter int DELAY_NUM  = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                per_img_vsync,
   input  logic                per_img_href,
   output logic [FIFO_NUM-1:0] fifo_wr_en,
   output logic [FIFO_NUM-1:0] fifo_rd_en,
   output logic                matrix_img_vsync,
   output logic                matrix_img_href,
   output logic                matrix_top_edge_flag,
   output logic                matrix_bottom_edge_flag,
   output logic                matrix_left_edge_flag,
   output logic                matrix_right_edge_flag,
   output logic                busy,
   output logic                frame_err
);

   localparam logic [10:0] H_LAST   = 11'(IMG_H_DISP - 1);
   localparam logic [10:0] V_LAST   = 11'(IMG_V_DISP - 1);
   localparam logic [10:0] GAP_LAST = 11'(DELAY_NUM - 1);

   state_t      state;
   state_t      state_next;
   logic [10:0] hcnt;
   logic [10:0] vcnt;
   logic [10:0] tcnt;
   logic [10:0] pix;
   logic        href_d;
   logic        vsync_flag;
   logic        href_fall;
   logic        in_rx;
   logic        abort;
   logic        line_on;
   logic        vs_set;
   logic        href_pre;
   logic        vsync_pre;
   logic        top_pre;
   logic        bottom_pre;
   logic        left_pre;
   logic        right_pre;
   logic [5:0]  win_in;
   logic [5:0]  win_out;

   assign href_fall = href_d & ~per_img_href;
   assign in_rx     = (state == FILL) || (state == ACTIVE);
   assign abort     = in_rx & ~per_img_vsync;
   assign line_on   = in_rx & per_img_vsync & per_img_href;
   assign vs_set    = (state == ACTIVE) && line_on && (vcnt == 11'd2) && (hcnt == 11'd0);
   assign busy      = (state != IDLE);

   // Input position counters. They only track live input while a frame can
   // be received; during the gap/tail rows input is ignored, so they are
   // held at zero there to start the next frame cleanly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         href_d <= 1'b0;
         hcnt   <= '0;
         vcnt   <= '0;
      end else begin
         href_d <= per_img_href;
         if (in_rx || state == IDLE) begin
            hcnt <= per_img_href ? hcnt + 11'd1 : 11'd0;
            if (!per_img_vsync) begin
               vcnt <= '0;
            end else if (href_fall) begin
               vcnt <= vcnt + 11'd1;
            end
         end else begin
            hcnt <= '0;
            vcnt <= '0;
         end
      end
   end

   // State register plus the cycle counter that times gap and tail rows.
   // tcnt restarts on every state change so each gap/tail state sees 0..N-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tcnt       <= '0;
         vsync_flag <= 1'b0;
      end else begin
         state <= state_next;
         if (state_next != state) begin
            tcnt <= '0;
         end else if (state == GAP1 || state == TAIL1 || state == GAP2 || state == TAIL2) begin
            tcnt <= tcnt + 11'd1;
         end else begin
            tcnt <= '0;
         end
         if (state_next == IDLE) begin
            vsync_flag <= 1'b0;
         end else if (vs_set) begin
            vsync_flag <= 1'b1;
         end
      end
   end

   // Next-state and pre-alignment outputs. FIFO k holds line (vcnt-k-1), so
   // it is written once line k has arrived and read once it holds data.
   // pix is the position inside the current window line, taken from hcnt for
   // live lines and from tcnt for tail rows.
   always_comb begin
      state_next = state;
      fifo_wr_en = '0;
      fifo_rd_en = '0;
      href_pre   = 1'b0;
      top_pre    = 1'b0;
      bottom_pre = 1'b0;
      pix        = hcnt;
      case (state)
         IDLE: begin
            if (per_img_vsync) state_next = FILL;
         end
         FILL, ACTIVE: begin
            for (int k = 0; k < FIFO_NUM; k++) begin
               fifo_wr_en[k] = line_on & (vcnt >= 11'(k));
               fifo_rd_en[k] = line_on & (vcnt > 11'(k));
            end
            if (state == ACTIVE) begin
               href_pre = line_on & (vcnt > 11'd1);
               top_pre  = href_pre & ((vcnt == 11'd2) || (vcnt == 11'd3));
            end
            if (abort) begin
               state_next = IDLE;
            end else if (state == FILL && href_fall && vcnt == 11'd1) begin
               state_next = ACTIVE;
            end else if (state == ACTIVE && line_on && hcnt == H_LAST && vcnt == V_LAST) begin
               state_next = GAP1;
            end
         end
         GAP1: begin
            if (tcnt == GAP_LAST) state_next = TAIL1;
         end
         TAIL1: begin
            fifo_wr_en = '1;
            fifo_rd_en = '1;
            href_pre   = 1'b1;
            bottom_pre = 1'b1;
            pix        = tcnt;
            if (tcnt == H_LAST) state_next = GAP2;
         end
         GAP2: begin
            if (tcnt == GAP_LAST) state_next = TAIL2;
         end
         TAIL2: begin
            fifo_rd_en = {{(FIFO_NUM-1){1'b1}}, 1'b0};
            href_pre   = 1'b1;
            bottom_pre = 1'b1;
            pix        = tcnt;
            if (tcnt == H_LAST) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign left_pre  = href_pre & (pix < 11'd2);
   assign right_pre = href_pre & (pix >= H_LAST - 11'd1);

   // The set term makes vsync_pre high on the very first window pixel; an
   // abort kills it in the same cycle the input frame disappears.
   assign vsync_pre = (vsync_flag | vs_set) & ~abort;

   assign win_in = {vsync_pre, href_pre, top_pre, bottom_pre, left_pre, right_pre};

   sig_delay_line #(
      .WIDTH (6),
      .DEPTH (WIN_LATENCY)
   ) u_align (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (win_in),
      .dout  (win_out)
   );

   assign {matrix_img_vsync, matrix_img_href, matrix_top_edge_flag,
           matrix_bottom_edge_flag, matrix_left_edge_flag, matrix_right_edge_flag} = win_out;

`ifdef FRAME_ERR_CHK_EN
   localparam logic [10:0] H_LEN = 11'(IMG_H_DISP);

   // A line ends on the href falling edge, where hcnt still holds its length.
   // A frame that loses vsync while lines are still expected is short.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err <= 1'b0;
      end else if (abort || (in_rx && href_fall && hcnt != H_LEN)) begin
         frame_err <= 1'b1;
      end
   end
`else
   assign frame_err = 1'b0;
`endif

endmodule
